// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : calc_pkg
// Purpose  : Shared key codes, operator and state encodings, and key
//            classification helpers for the calculator entry sequencer.
// Contents : KEY_* key code constants, calc_op_t (2-bit operator),
//            calc_state_t (3-bit sequencer state), is_digit/is_operator,
//            key_to_op.
// Revision : 1.0 - initial release
// ============================================================================
package calc_pkg;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_MUL = 4'hC;
    localparam logic [3:0] KEY_CLR = 4'hD;
    localparam logic [3:0] KEY_EQ  = 4'hE;
    localparam logic [3:0] KEY_BS  = 4'hF;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2
    } calc_op_t;

    typedef enum logic [2:0] {
        ST_ENTER_A = 3'd0,
        ST_ENTER_B = 3'd1,
        ST_WAIT    = 3'd2,
        ST_RESULT  = 3'd3,
        ST_ERROR   = 3'd4
    } calc_state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

    function automatic logic is_operator(input logic [3:0] code);
        return (code == KEY_ADD) || (code == KEY_SUB) || (code == KEY_MUL);
    endfunction

    // Non-operator codes map to add; callers only use this on operator keys.
    function automatic calc_op_t key_to_op(input logic [3:0] code);
        calc_op_t op;
        case (code)
            KEY_SUB: op = OP_SUB;
            KEY_MUL: op = OP_MUL;
            default: op = OP_ADD;
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_entry_reg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_entry_reg
// Purpose  : One BCD operand being typed in: a nibble shift register plus a
//            digit counter running 0..DIGITS.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            i_clear         - zero value and count (may combine with push)
//            i_load          - load i_load_value, count becomes DIGITS
//            i_push/i_digit  - shift left and insert digit in low nibble
//            i_pop           - shift right, drop the low digit
//            o_value/o_count - current operand and number of digits held
// Revision : 1.0 - initial release
// ============================================================================
module bcd_entry_reg #(
    parameter int DIGITS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_clear,
    input  logic                         i_load,
    input  logic [4*DIGITS-1:0]          i_load_value,
    input  logic                         i_push,
    input  logic [3:0]                   i_digit,
    input  logic                         i_pop,
    output logic [4*DIGITS-1:0]          o_value,
    output logic [$clog2(DIGITS+1)-1:0]  o_count
);

    localparam int c_val_w = 4 * DIGITS;
    localparam int c_cnt_w = $clog2(DIGITS + 1);
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DIGITS);

    logic [c_val_w-1:0] r_value;
    logic [c_val_w-1:0] w_base_val;
    logic [c_val_w-1:0] w_value_nxt;
    logic [c_cnt_w-1:0] r_count;
    logic [c_cnt_w-1:0] w_base_cnt;
    logic [c_cnt_w-1:0] w_count_nxt;

    // Clear is applied first so that "clear and push" starts a fresh operand
    // holding just the new digit in a single cycle.
    always_comb begin
        w_base_val  = i_clear ? '0 : r_value;
        w_base_cnt  = i_clear ? '0 : r_count;
        w_value_nxt = w_base_val;
        w_count_nxt = w_base_cnt;
        if (i_load) begin
            w_value_nxt = i_load_value;
            w_count_nxt = c_full;
        end else if (i_push) begin
            // Full operand ignores the digit; a leading zero is not counted.
            if ((w_base_cnt != c_full) &&
                !((w_base_cnt == '0) && (i_digit == 4'd0))) begin
                w_value_nxt = (w_base_val << 4) | c_val_w'(i_digit);
                w_count_nxt = w_base_cnt + c_cnt_w'(1);
            end
        end else if (i_pop) begin
            if (w_base_cnt != '0) begin
                w_value_nxt = w_base_val >> 4;
                w_count_nxt = w_base_cnt - c_cnt_w'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= '0;
            r_count <= '0;
        end else begin
            r_value <= w_value_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign o_value = r_value;
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/calc_entry_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : calc_entry_sequencer
// Purpose  : Turns keypad strobes into two BCD operands and an operator,
//            runs a req/ack transaction with the arithmetic unit, and holds
//            the value shown on the display.
// Ports    : clock, reset              - clock, asynchronous active-high reset
//            key_valid, key_code       - one-cycle key strobe and hex code
//            alu_req, alu_op           - compute request and operator
//            alu_a, alu_b              - BCD operands, stable while alu_req
//            alu_ack, alu_result,
//            alu_err                   - completion pulse, result, error flag
//            disp_value, disp_err      - display value and error indicator
//            busy                      - waiting on the arithmetic unit
// Revision : 1.0 - initial release
// ============================================================================
module calc_entry_sequencer #(
    parameter int DIGITS = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  key_valid,
    input  logic [3:0]            key_code,
    output logic                  alu_req,
    output logic [1:0]            alu_op,
    output logic [4*DIGITS-1:0]   alu_a,
    output logic [4*DIGITS-1:0]   alu_b,
    input  logic                  alu_ack,
    input  logic [4*DIGITS-1:0]   alu_result,
    input  logic                  alu_err,
    output logic [4*DIGITS-1:0]   disp_value,
    output logic                  disp_err,
    output logic                  busy
);

    import calc_pkg::*;

    localparam int c_val_w = 4 * DIGITS;
    localparam int c_cnt_w = $clog2(DIGITS + 1);

    calc_state_t        r_state, w_state_nxt;
    calc_op_t           r_op, w_op_nxt;
    calc_op_t           r_pend_op, w_pend_nxt;
    logic               r_chain, w_chain_nxt;
    logic [c_val_w-1:0] r_result, w_result_nxt;
    logic [c_val_w-1:0] r_disp_last, w_disp;

    logic [c_val_w-1:0] w_a_val, w_b_val, w_a_load_value;
    logic [c_cnt_w-1:0] w_b_cnt;
    // A's digit count only matters inside its entry register.
    logic [c_cnt_w-1:0] w_a_cnt_unused;

    logic w_is_digit, w_is_op, w_is_eq, w_is_bs, w_clr, w_chain_ld;
    logic w_a_clear, w_a_load, w_a_push, w_a_pop;
    logic w_b_clear, w_b_push, w_b_pop;

    // Keys are dead while waiting on the ALU, including the ack cycle.
    assign w_is_digit = key_valid && is_digit(key_code) && (r_state != ST_WAIT);
    assign w_is_op    = key_valid && is_operator(key_code) && (r_state != ST_WAIT);
    assign w_is_eq    = key_valid && (key_code == KEY_EQ) && (r_state != ST_WAIT);
    assign w_is_bs    = key_valid && (key_code == KEY_BS) && (r_state != ST_WAIT);
    assign w_clr      = key_valid && (key_code == KEY_CLR) && (r_state != ST_WAIT);
    assign w_chain_ld = (r_state == ST_WAIT) && alu_ack && !alu_err && r_chain;

    // Operand A edit controls
    assign w_a_clear = w_clr || ((r_state == ST_RESULT) && w_is_digit);
    assign w_a_push  = w_is_digit && ((r_state == ST_ENTER_A) || (r_state == ST_RESULT));
    assign w_a_pop   = w_is_bs && (r_state == ST_ENTER_A);
    assign w_a_load  = w_chain_ld || ((r_state == ST_RESULT) && w_is_op);
    assign w_a_load_value = (r_state == ST_WAIT) ? alu_result : r_result;

    // Operand B is emptied whenever a fresh B is about to be typed.
    assign w_b_clear = w_clr || w_chain_ld ||
                       (((r_state == ST_ENTER_A) || (r_state == ST_RESULT)) && w_is_op);
    assign w_b_push  = w_is_digit && (r_state == ST_ENTER_B);
    assign w_b_pop   = w_is_bs && (r_state == ST_ENTER_B);

    bcd_entry_reg #(.DIGITS(DIGITS)) u_entry_a (
        .clk          (clock),
        .rst          (reset),
        .i_clear      (w_a_clear),
        .i_load       (w_a_load),
        .i_load_value (w_a_load_value),
        .i_push       (w_a_push),
        .i_digit      (key_code),
        .i_pop        (w_a_pop),
        .o_value      (w_a_val),
        .o_count      (w_a_cnt_unused)
    );

    bcd_entry_reg #(.DIGITS(DIGITS)) u_entry_b (
        .clk          (clock),
        .rst          (reset),
        .i_clear      (w_b_clear),
        .i_load       (1'b0),
        .i_load_value ('0),
        .i_push       (w_b_push),
        .i_digit      (key_code),
        .i_pop        (w_b_pop),
        .o_value      (w_b_val),
        .o_count      (w_b_cnt)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_op_nxt     = r_op;
        w_pend_nxt   = r_pend_op;
        w_chain_nxt  = r_chain;
        w_result_nxt = r_result;
        if (r_state == ST_WAIT) begin
            if (alu_ack) begin
                if (alu_err) begin
                    w_state_nxt = ST_ERROR;
                end else begin
                    w_result_nxt = alu_result;
                    if (r_chain) begin
                        w_state_nxt = ST_ENTER_B;
                        w_op_nxt    = r_pend_op;
                    end else begin
                        w_state_nxt = ST_RESULT;
                    end
                end
            end
        end else if (w_clr) begin
            w_state_nxt  = ST_ENTER_A;
            w_result_nxt = '0;
        end else begin
            case (r_state)
                ST_ENTER_A: begin
                    if (w_is_op) begin
                        w_op_nxt    = key_to_op(key_code);
                        w_state_nxt = ST_ENTER_B;
                    end
                end
                ST_ENTER_B: begin
                    if (w_is_op) begin
                        if (w_b_cnt == '0) begin
                            w_op_nxt = key_to_op(key_code);
                        end else begin
                            // Operator after a complete B: compute now, keep
                            // the new operator for the follow-on operand.
                            w_pend_nxt  = key_to_op(key_code);
                            w_chain_nxt = 1'b1;
                            w_state_nxt = ST_WAIT;
                        end
                    end else if (w_is_eq && (w_b_cnt != '0)) begin
                        w_chain_nxt = 1'b0;
                        w_state_nxt = ST_WAIT;
                    end
                end
                ST_RESULT: begin
                    if (w_is_digit) begin
                        w_state_nxt = ST_ENTER_A;
                    end else if (w_is_op) begin
                        w_op_nxt    = key_to_op(key_code);
                        w_state_nxt = ST_ENTER_B;
                    end
                end
                default: ;
            endcase
        end
    end

    // WAIT falls through to the last shown value so the display freezes.
    always_comb begin
        case (r_state)
            ST_ENTER_A: w_disp = w_a_val;
            ST_ENTER_B: w_disp = (w_b_cnt != '0) ? w_b_val : w_a_val;
            ST_RESULT:  w_disp = r_result;
            ST_ERROR:   w_disp = '0;
            default:    w_disp = r_disp_last;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_ENTER_A;
            r_op        <= OP_ADD;
            r_pend_op   <= OP_ADD;
            r_chain     <= 1'b0;
            r_result    <= '0;
            r_disp_last <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_op        <= w_op_nxt;
            r_pend_op   <= w_pend_nxt;
            r_chain     <= w_chain_nxt;
            r_result    <= w_result_nxt;
            r_disp_last <= w_disp;
        end
    end

    assign alu_req    = (r_state == ST_WAIT);
    assign busy       = (r_state == ST_WAIT);
    assign alu_op     = r_op;
    assign alu_a      = w_a_val;
    assign alu_b      = w_b_val;
    assign disp_value = w_disp;
    assign disp_err   = (r_state == ST_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_calc_entry_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_entry_sequencer
// Purpose  : Self-checking bench for calc_entry_sequencer. A decimal-valued
//            reference model tracks operands, operator and mode; a small ALU
//            model answers requests with a programmable or random latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_entry_sequencer;

    localparam int DIGITS = 4;
    localparam int MAXV   = 9999;

    localparam logic [3:0] K_EQ  = 4'hE;
    localparam logic [3:0] K_CLR = 4'hD;
    localparam logic [3:0] K_BS  = 4'hF;

    // reference model modes
    localparam int M_ENTER_A = 10;
    localparam int M_ENTER_B = 11;
    localparam int M_WAIT    = 12;
    localparam int M_RESULT  = 13;
    localparam int M_ERROR   = 14;

    logic        clock;
    logic        reset;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        alu_req;
    logic [1:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_ack;
    logic [15:0] alu_result;
    logic        alu_err;
    logic [15:0] disp_value;
    logic        disp_err;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    int m_st, m_a, m_acnt, m_b, m_bcnt, m_op, m_pend, m_chain, m_result, m_disp, m_wait;
    int fix_delay = -1;
    bit force_err = 1'b0;

    calc_entry_sequencer #(.DIGITS(DIGITS)) dut (
        .clock      (clock),
        .reset      (reset),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .alu_req    (alu_req),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ack    (alu_ack),
        .alu_result (alu_result),
        .alu_err    (alu_err),
        .disp_value (disp_value),
        .disp_err   (disp_err),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic bit can_push(input int cnt, input int d);
        return (cnt < DIGITS) && !((cnt == 0) && (d == 0));
    endfunction

    task automatic model_reset();
        m_st = M_ENTER_A;
        m_a = 0; m_acnt = 0; m_b = 0; m_bcnt = 0;
        m_op = 0; m_pend = 0; m_chain = 0; m_result = 0; m_disp = 0; m_wait = 0;
    endtask

    task automatic enter_wait(input int chain);
        m_chain = chain;
        m_st = M_WAIT;
        m_wait = (fix_delay >= 0) ? fix_delay : int'($urandom_range(0, 3));
    endtask

    task automatic model_step(input bit kv, input logic [3:0] kc, input bit ack,
                              input int rdec, input bit err);
        int d;
        d = int'(kc);
        if (m_st == M_WAIT) begin
            if (ack) begin
                if (err) begin
                    m_st = M_ERROR;
                end else begin
                    m_result = rdec;
                    if (m_chain != 0) begin
                        m_a = rdec; m_acnt = DIGITS; m_op = m_pend;
                        m_b = 0; m_bcnt = 0; m_st = M_ENTER_B;
                    end else begin
                        m_st = M_RESULT;
                    end
                end
            end
        end else if (kv && kc == K_CLR) begin
            m_a = 0; m_acnt = 0; m_b = 0; m_bcnt = 0; m_result = 0;
            m_st = M_ENTER_A;
        end else if (kv) begin
            case (m_st)
                M_ENTER_A: begin
                    if (d <= 9) begin
                        if (can_push(m_acnt, d)) begin m_a = m_a * 10 + d; m_acnt++; end
                    end else if (kc == K_BS) begin
                        if (m_acnt > 0) begin m_a = m_a / 10; m_acnt--; end
                    end else if (d >= 10 && d <= 12) begin
                        m_op = d - 10; m_b = 0; m_bcnt = 0; m_st = M_ENTER_B;
                    end
                end
                M_ENTER_B: begin
                    if (d <= 9) begin
                        if (can_push(m_bcnt, d)) begin m_b = m_b * 10 + d; m_bcnt++; end
                    end else if (kc == K_BS) begin
                        if (m_bcnt > 0) begin m_b = m_b / 10; m_bcnt--; end
                    end else if (d >= 10 && d <= 12) begin
                        if (m_bcnt == 0) m_op = d - 10;
                        else begin m_pend = d - 10; enter_wait(1); end
                    end else if (kc == K_EQ && m_bcnt > 0) begin
                        enter_wait(0);
                    end
                end
                M_RESULT: begin
                    if (d <= 9) begin
                        m_a = 0; m_acnt = 0;
                        if (can_push(m_acnt, d)) begin m_a = d; m_acnt = 1; end
                        m_st = M_ENTER_A;
                    end else if (d >= 10 && d <= 12) begin
                        m_a = m_result; m_acnt = DIGITS; m_op = d - 10;
                        m_b = 0; m_bcnt = 0; m_st = M_ENTER_B;
                    end
                end
                default: ;
            endcase
        end
        case (m_st)
            M_ENTER_A: m_disp = m_a;
            M_ENTER_B: m_disp = (m_bcnt > 0) ? m_b : m_a;
            M_RESULT:  m_disp = m_result;
            M_ERROR:   m_disp = 0;
            default:   ;
        endcase
    endtask

    task automatic check_outputs();
        check_eq("req",  32'(alu_req),    32'(m_st == M_WAIT));
        check_eq("busy", 32'(busy),       32'(m_st == M_WAIT));
        check_eq("a",    32'(alu_a),      32'(to_bcd(m_a)));
        check_eq("b",    32'(alu_b),      32'(to_bcd(m_b)));
        check_eq("disp", 32'(disp_value), 32'(to_bcd(m_disp)));
        check_eq("derr", 32'(disp_err),   32'(m_st == M_ERROR));
        if (m_st == M_WAIT) check_eq("op", 32'(alu_op), 32'(m_op));
    endtask

    // One clock: drive key and ALU response, let the edge happen, advance
    // the model, then compare after the edge.
    task automatic tick(input bit kv, input logic [3:0] kc, input bit spur);
        bit          ack;
        bit          err;
        int          rdec;
        logic [15:0] rbcd;
        ack  = 1'b0;
        err  = 1'b0;
        rdec = 0;
        rbcd = 16'($urandom);
        if (m_st == M_WAIT) begin
            if (m_wait == 0) begin
                ack = 1'b1;
                case (m_op)
                    0:       rdec = m_a + m_b;
                    1:       rdec = m_a - m_b;
                    default: rdec = m_a * m_b;
                endcase
                err = force_err || (rdec < 0) || (rdec > MAXV);
                if (!err) rbcd = to_bcd(rdec);
            end else begin
                m_wait--;
            end
        end else if (spur) begin
            ack = 1'b1;
            err = 1'($urandom);
        end
        key_valid  = kv;
        key_code   = kc;
        alu_ack    = ack;
        alu_err    = err;
        alu_result = rbcd;
        @(posedge clock);
        model_step(kv, kc, ack, rdec, err);
        #1;
        key_valid = 1'b0;
        alu_ack   = 1'b0;
        check_outputs();
    endtask

    task automatic press(input logic [3:0] kc);
        tick(1'b1, kc, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 4'h0, 1'b0);
    endtask

    task automatic settle();
        for (int i = 0; i < 20 && m_st == M_WAIT; i++) tick(1'b0, 4'h0, 1'b0);
        press(K_CLR);
    endtask

    function automatic logic [3:0] pick_key();
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 50)      return 4'($urandom_range(0, 9));
        else if (r < 64) return 4'($urandom_range(10, 12));
        else if (r < 74) return K_EQ;
        else if (r < 85) return K_BS;
        else if (r < 90) return K_CLR;
        else             return 4'($urandom_range(0, 15));
    endfunction

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_req"},  32'(alu_req),    32'd0);
        check_eq({tag, "_busy"}, 32'(busy),       32'd0);
        check_eq({tag, "_op"},   32'(alu_op),     32'd0);
        check_eq({tag, "_a"},    32'(alu_a),      32'd0);
        check_eq({tag, "_b"},    32'(alu_b),      32'd0);
        check_eq({tag, "_disp"}, 32'(disp_value), 32'd0);
        check_eq({tag, "_derr"}, 32'(disp_err),   32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int reqc;
        reset = 1'b1; key_valid = 1'b0; key_code = 4'h0;
        alu_ack = 1'b0; alu_result = '0; alu_err = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_reset_values("rst");
        reset = 1'b0;

        // 12 + 34, three-cycle request
        fix_delay = 2;
        press(4'h1); press(4'h2); press(4'hA); press(4'h3); press(4'h4); press(K_EQ);
        check_eq("t1_a",  32'(alu_a),  32'h0012);
        check_eq("t1_b",  32'(alu_b),  32'h0034);
        check_eq("t1_op", 32'(alu_op), 32'd0);
        reqc = 0;
        for (int i = 0; i < 10; i++) begin
            if (!alu_req) break;
            reqc++;
            tick(1'b0, 4'h0, 1'b0);
        end
        check_eq("t1_reqlen", 32'(reqc), 32'd3);
        check_eq("t1_disp", 32'(disp_value), 32'h0046);

        // digit limit and backspace
        settle();
        press(4'h9); press(4'h8); press(4'h7); press(4'h6); press(4'h5);
        check_eq("t2_full", 32'(alu_a), 32'h9876);
        press(K_BS); press(K_BS);
        check_eq("t2_bs", 32'(alu_a), 32'h0098);
        press(4'h1);
        check_eq("t2_cnt", 32'(alu_a), 32'h0981);

        // chained 5 - 3, then * 2, ack in the first request cycle
        settle();
        fix_delay = 0;
        press(4'h5); press(4'hA); press(4'hB); press(4'h3); press(4'hC);
        check_eq("t3_op1", 32'(alu_op), 32'd1);
        check_eq("t3_a1",  32'(alu_a),  32'h0005);
        check_eq("t3_b1",  32'(alu_b),  32'h0003);
        idle(1);
        check_eq("t3_chain_a",    32'(alu_a),      32'h0002);
        check_eq("t3_chain_disp", 32'(disp_value), 32'h0002);
        press(4'h2); press(K_EQ);
        check_eq("t3_op2", 32'(alu_op), 32'd2);
        check_eq("t3_a2",  32'(alu_a),  32'h0002);
        check_eq("t3_b2",  32'(alu_b),  32'h0002);
        idle(1);
        check_eq("t3_res", 32'(disp_value), 32'h0004);

        // error path
        settle();
        fix_delay = 1;
        force_err = 1'b1;
        press(4'h1); press(4'hA); press(4'h1); press(K_EQ);
        idle(3);
        force_err = 1'b0;
        check_eq("t4_derr", 32'(disp_err),   32'd1);
        check_eq("t4_disp", 32'(disp_value), 32'd0);
        press(4'h5);
        check_eq("t4_dig_derr", 32'(disp_err), 32'd1);
        press(K_CLR);
        check_eq("t4_clr_derr", 32'(disp_err), 32'd0);
        check_eq("t4_clr_busy", 32'(busy),     32'd0);

        // keys ignored in WAIT, asynchronous reset mid-request
        settle();
        fix_delay = 8;
        press(4'h1); press(4'hA); press(4'h2); press(K_EQ);
        press(4'h7); press(K_CLR);
        check_eq("t5_req", 32'(alu_req), 32'd1);
        check_eq("t5_a",   32'(alu_a),   32'h0001);
        check_eq("t5_b",   32'(alu_b),   32'h0002);
        #2 reset = 1'b1;
        #1;
        check_eq("t5_async_req", 32'(alu_req), 32'd0);
        check_reset_values("t5_rst");
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
        tick(1'b0, 4'h0, 1'b1);
        check_eq("t5_late_ack_busy", 32'(busy), 32'd0);
        fix_delay = -1;

        // randomized traffic with occasional stray acks
        for (int i = 0; i < 3000; i++) begin
            bit kv;
            logic [3:0] kc;
            kv = ($urandom_range(0, 99) < 55);
            kc = kv ? pick_key() : 4'($urandom);
            tick(kv, kc, ($urandom_range(0, 29) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
